// File: rtl/fix2flt_pkg.sv
// ---------------------------------------------------------------------------
// fix2flt_pkg
// Shared definitions for the fixed-point to half-precision converter:
//   - state_t      : converter FSM states (IDLE, NORM, PACK, DONE)
//   - FRAC_BITS_DEF / EXP_BIAS_DEF : default parameter values (8.8 input,
//                    IEEE half-precision bias)
//   - *_W          : field widths of the half-precision word and the
//                    sign-and-magnitude input magnitude
// ---------------------------------------------------------------------------
package fix2flt_pkg;

    localparam int SIGN_W = 1;
    localparam int EXP_W  = 5;
    localparam int MANT_W = 10;
    localparam int MAG_W  = 15;
    localparam int FLT_W  = SIGN_W + EXP_W + MANT_W;

    localparam int FRAC_BITS_DEF = 8;
    localparam int EXP_BIAS_DEF  = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        PACK = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage : fix2flt_pkg

// File: rtl/fix2flt_rnd.sv
// ---------------------------------------------------------------------------
// fix2flt_rnd
// Combinational packer: turns a normalised magnitude (leading one in bit 14,
// or all-zero) plus sign and biased exponent into a half-precision word.
//
// Configuration macro: FIX2FLT_ROUND_EN
//   undefined : truncate, mag[3:0] are discarded
//   defined   : round to nearest-even (guard = mag[3], sticky = |mag[2:0],
//               lsb = mag[4]); a mantissa carry-out clears the mantissa and
//               bumps the exponent by one
//
// Ports:
//   sign    in   sign bit to pass through
//   mag     in   normalised magnitude
//   exp_in  in   biased exponent matching mag
//   flt     out  {sign, exp, mant}; zero magnitude gives {sign, 15'b0}
// ---------------------------------------------------------------------------
module fix2flt_rnd
    import fix2flt_pkg::*;
(
    input  logic             sign,
    input  logic [MAG_W-1:0] mag,
    input  logic [EXP_W-1:0] exp_in,
    output logic [FLT_W-1:0] flt
);

    logic [MANT_W-1:0] mant;
    logic [EXP_W-1:0]  exp_v;

`ifdef FIX2FLT_ROUND_EN
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [MANT_W:0]   mant_sum;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        mant  = mag[13:4];
        exp_v = exp_in;
`ifdef FIX2FLT_ROUND_EN
        guard    = mag[3];
        sticky   = |mag[2:0];
        round_up = guard & (sticky | mag[4]);
        mant_sum = {1'b0, mag[13:4]} + {{MANT_W{1'b0}}, round_up};
        mant     = mant_sum[MANT_W-1:0];
        // All-ones mantissa rounding up: 1.111..1 becomes 10.000..0, so the
        // mantissa is already zero and only the exponent moves.
        if (mant_sum[MANT_W]) begin
            exp_v = exp_in + {{(EXP_W-1){1'b0}}, 1'b1};
        end
`endif
        if (mag == '0) begin
            flt = {sign, {(EXP_W+MANT_W){1'b0}}};
        end else begin
            flt = {sign, exp_v, mant};
        end
    end

endmodule : fix2flt_rnd

// File: rtl/fix2flt_seq.sv
// ---------------------------------------------------------------------------
// fix2flt_seq
// Sequential converter from 16-bit sign-and-magnitude fixed point
// (FRAC_BITS fraction bits) to IEEE half precision. The magnitude is
// normalised one left shift per cycle, then packed (and optionally rounded)
// by fix2flt_rnd. Latency from the start edge to done is shifts + 2 cycles.
//
// Configuration macro: FIX2FLT_ROUND_EN (see fix2flt_rnd); default truncates.
//
// Parameters:
//   FRAC_BITS  fraction bits of fix_in (default 8)
//   EXP_BIAS   exponent bias of the result (default 15)
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-low reset
//   start    in   one-cycle request; fix_in sampled on that edge (IDLE/DONE)
//   fix_in   in   {sign, magnitude[14:0]}
//   flt_out  out  registered half-precision result, held until next PACK
//   busy     out  high in NORM and PACK; start is ignored then
//   done     out  one-cycle pulse, flt_out valid
// ---------------------------------------------------------------------------
module fix2flt_seq
    import fix2flt_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int EXP_BIAS  = EXP_BIAS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [FLT_W-1:0] fix_in,
    output logic [FLT_W-1:0] flt_out,
    output logic             busy,
    output logic             done
);

    // A leading one in magnitude bit 14 with FRAC_BITS fraction bits is worth
    // 2**(14-FRAC_BITS); each normalising shift lowers that by one.
    localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(MAG_W - 1 - FRAC_BITS + EXP_BIAS);

    state_t            state_q, state_d;
    logic              sign_q;
    logic [MAG_W-1:0]  mag_q;
    logic [EXP_W-1:0]  exp_q;
    logic [FLT_W-1:0]  flt_q;
    logic [FLT_W-1:0]  flt_pack;

    logic              capture;
    logic              shift;
    logic              load_out;

    // Next-state and control decode.
    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        shift    = 1'b0;
        load_out = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    state_d = NORM;
                end
            end
            NORM: begin
                busy = 1'b1;
                if (mag_q == '0 || mag_q[MAG_W-1]) begin
                    state_d = PACK;
                end else begin
                    shift = 1'b1;
                end
            end
            PACK: begin
                busy     = 1'b1;
                load_out = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    capture = 1'b1;
                    state_d = NORM;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the datapath registers are reset too, so an aborted conversion
    // leaves no stale operand or result behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sign_q <= 1'b0;
            mag_q  <= '0;
            exp_q  <= '0;
            flt_q  <= '0;
        end else begin
            if (capture) begin
                sign_q <= fix_in[FLT_W-1];
                mag_q  <= fix_in[MAG_W-1:0];
                exp_q  <= EXP_INIT;
            end else if (shift) begin
                mag_q  <= {mag_q[MAG_W-2:0], 1'b0};
                exp_q  <= exp_q - {{(EXP_W-1){1'b0}}, 1'b1};
            end
            if (load_out) begin
                flt_q <= flt_pack;
            end
        end
    end

    fix2flt_rnd u_rnd (
        .sign   (sign_q),
        .mag    (mag_q),
        .exp_in (exp_q),
        .flt    (flt_pack)
    );

    assign flt_out = flt_q;

endmodule : fix2flt_seq

// File: tb/tb_fix2flt_seq.sv
// ---------------------------------------------------------------------------
// tb_fix2flt_seq
// Directed bench for fix2flt_seq. Expected results are hand-computed
// half-precision encodings; the 0x7FFF and 0x4018 vectors follow
// FIX2FLT_ROUND_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_fix2flt_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] fix_in;
    logic [15:0] flt_out;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    localparam int TIMEOUT = 40;

    fix2flt_seq dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .fix_in  (fix_in),
        .flt_out (flt_out),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after the edge that sampled start. Leaves the bench #1 after
    // the edge on which done is first seen high (or the budget ran out).
    task automatic wait_done(input string tag, input logic [15:0] exp_flt, input int exp_lat);
        int cycles;
        check({tag, "_busy_in_norm"}, 32'(busy), 32'd1);
        cycles = 0;
        while (!done && cycles < TIMEOUT) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
        check({tag, "_flt"}, 32'(flt_out), 32'(exp_flt));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    task automatic issue(input logic [15:0] v);
        @(posedge clk);
        #1;
        fix_in = v;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic done_falls(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [15:0] exp_7fff;
        logic [15:0] exp_4018;
        logic        saw_done;

        checks   = 0;
        failures = 0;
        start    = 1'b0;
        fix_in   = 16'h0000;
        reset    = 1'b0;

`ifdef FIX2FLT_ROUND_EN
        exp_7fff = 16'h5800;
        exp_4018 = 16'h5402;
`else
        exp_7fff = 16'h57FF;
        exp_4018 = 16'h5401;
`endif

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_flt", 32'(flt_out), 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        // First start right after reset release is taken on the first edge.
        @(negedge clk);
        reset = 1'b1;
        fix_in = 16'h0100;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("one", 16'h3C00, 8);
        done_falls("one");

        issue(16'h8180);
        wait_done("neg1p5", 16'hBE00, 8);
        done_falls("neg1p5");

        issue(16'h7FFF);
        wait_done("max", exp_7fff, 2);
        done_falls("max");

        issue(16'h0A80);
        wait_done("ten5", 16'h4940, 5);

        // Restart straight from DONE.
        fix_in = 16'h8000;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("negzero", 16'h8000, 2);
        done_falls("negzero");

        issue(16'h0001);
        wait_done("min", 16'h1C00, 16);
        done_falls("min");

        issue(16'h4008);
        wait_done("tie_even", 16'h5400, 2);
        done_falls("tie_even");

        issue(16'h4018);
        wait_done("tie_odd", exp_4018, 2);
        done_falls("tie_odd");

        issue(16'h0000);
        wait_done("zero", 16'h0000, 2);
        done_falls("zero");

        // start while busy is ignored.
        issue(16'h0001);
        repeat (3) @(posedge clk);
        #1;
        fix_in = 16'h0100;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        begin
            int cycles;
            cycles = 4;
            while (!done && cycles < TIMEOUT) begin
                @(posedge clk);
                #1;
                cycles++;
            end
            check("busy_ign_latency", 32'(cycles), 32'd16);
            check("busy_ign_flt", 32'(flt_out), 32'h1C00);
        end
        done_falls("busy_ign");
        repeat (3) @(posedge clk);
        #1;
        check("busy_ign_no_extra_done", 32'(done), 32'd0);

        // Reset in the middle of NORM.
        issue(16'h0001);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("midrst_flt", 32'(flt_out), 32'h0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            saw_done = saw_done | done;
        end
        check("midrst_no_done", 32'(saw_done), 32'd0);

        issue(16'h8180);
        wait_done("post_rst", 16'hBE00, 8);
        done_falls("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fix2flt_seq
